// File: rtl/ahb_default_slave_pkg.sv
// Shared AHB types and helpers for the default slave and its error log.
package ahb_default_slave_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'b000,
        SIZE_HALF   = 3'b001,
        SIZE_WORD   = 3'b010,
        SIZE_DWORD  = 3'b011,
        SIZE_4WORD  = 3'b100,
        SIZE_8WORD  = 3'b101,
        SIZE_16WORD = 3'b110,
        SIZE_32WORD = 3'b111
    } hsize_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } defslv_state_type;

    localparam int unsigned WAIT_CNT_WIDTH = 4;
    typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_type;

    // Only NONSEQ and SEQ carry a real transfer that needs an answer.
    function automatic logic is_active_trans(htrans_type t);
        return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_defslv_err_log.sv
// Error log for the AHB default slave: last faulting address/direction,
// saturating error counter and sticky interrupt, with clear-vs-accept priority.
module ahb_defslv_err_log
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic                      accept_i,
    input  logic                      err_clr_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic                      hwrite_i,
    output logic [ERR_CNT_WIDTH-1:0]  err_count_o,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr_o,
    output logic                      err_write_o,
    output logic                      err_irq_o
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [ERR_CNT_WIDTH-1:0]  count_q, count_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic                      irq_q, irq_d;

    // A new error in the same cycle as a clear wins: the count restarts at one.
    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        write_d = write_q;
        irq_d   = irq_q;
        if (accept_i) begin
            addr_d  = haddr_i;
            write_d = hwrite_i;
            irq_d   = 1'b1;
            if (err_clr_i) begin
                count_d = ERR_CNT_WIDTH'(1);
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + ERR_CNT_WIDTH'(1);
            end
        end else if (err_clr_i) begin
            count_d = '0;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            count_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            irq_q   <= irq_d;
        end
    end

    assign err_count_o = count_q;
    assign err_addr_o  = addr_q;
    assign err_write_o = write_q;
    assign err_irq_o   = irq_q;

endmodule

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for unmapped NONSEQ/SEQ, OKAY otherwise.
// Optional error log enabled by defining AHB_DEFSLV_ERRLOG_EN.
module ahb_default_slave
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH  = 32,
    parameter int ERR_WAIT_CYCLES = 0,
    parameter int ERR_CNT_WIDTH   = 8
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
    input  logic                      hwrite,
    input  hsize_type                 hsize,
    input  logic                      hready,
    output logic                      hreadyout,
    output hresp_type                 hresp,
    input  logic                      err_clr,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic                      err_write,
    output logic                      err_irq
);

    localparam wait_cnt_type WAIT_LOAD = wait_cnt_type'(ERR_WAIT_CYCLES);

    defslv_state_type state_q, state_d;
    wait_cnt_type     wait_cnt_q, wait_cnt_d;
    logic             hreadyout_q, hreadyout_d;
    hresp_type        hresp_q, hresp_d;
    logic             accept;

    // Only IDLE and ERR2 present hreadyout=1, so only they may take a new transfer.
    assign accept = hsel && hready && is_active_trans(htrans)
                    && ((state_q == ST_IDLE) || (state_q == ST_ERR2));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (ERR_WAIT_CYCLES == 0) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == wait_cnt_type'(1)) begin
                    state_d = ST_ERR1;
                end else begin
                    wait_cnt_d = wait_cnt_q - wait_cnt_type'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Response flops follow the next state so outputs never see haddr/htrans combinationally.
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? ERROR : OKAY;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= OKAY;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

    // Transfer size is accepted on the bus but never affects the response.
    logic unused_hsize;
    assign unused_hsize = ^hsize;

`ifdef AHB_DEFSLV_ERRLOG_EN
    ahb_defslv_err_log #(
        .AHB_ADDR_WIDTH (AHB_ADDR_WIDTH),
        .ERR_CNT_WIDTH  (ERR_CNT_WIDTH)
    ) u_err_log (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .accept_i    (accept),
        .err_clr_i   (err_clr),
        .haddr_i     (haddr),
        .hwrite_i    (hwrite),
        .err_count_o (err_count),
        .err_addr_o  (err_addr),
        .err_write_o (err_write),
        .err_irq_o   (err_irq)
    );
`else
    logic unused_log_inputs;
    assign unused_log_inputs = ^{err_clr, haddr, hwrite, accept};

    assign err_count = '0;
    assign err_addr  = '0;
    assign err_write = 1'b0;
    assign err_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_default_slave.sv
// Scoreboard bench for ahb_default_slave: two instances (zero and three wait states)
// checked every cycle against a sequence-position model of the ERROR response.
module tb_ahb_default_slave;
    import ahb_default_slave_pkg::*;

    localparam int AW  = 32;
    localparam int W0  = 0;
    localparam int CW0 = 8;
    localparam int W1  = 3;
    localparam int CW1 = 2;
`ifdef AHB_DEFSLV_ERRLOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic hclk     = 1'b0;
    logic hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    logic       hsel    = 1'b0;
    logic [AW-1:0] haddr = '0;
    htrans_type htrans  = TRANS_IDLE;
    logic       hwrite  = 1'b0;
    hsize_type  hsize   = SIZE_WORD;
    logic       err_clr = 1'b0;
    logic       hready0 = 1'b1;
    logic       hready1 = 1'b1;

    logic           rdy0, rdy1;
    hresp_type      resp0, resp1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;
    logic [AW-1:0]  addr0, addr1;
    logic           wr0, wr1, irq0, irq1;

    ahb_default_slave #(.AHB_ADDR_WIDTH(AW), .ERR_WAIT_CYCLES(W0), .ERR_CNT_WIDTH(CW0)) dut0 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready0), .hreadyout(rdy0), .hresp(resp0),
        .err_clr(err_clr), .err_count(cnt0), .err_addr(addr0), .err_write(wr0), .err_irq(irq0)
    );

    ahb_default_slave #(.AHB_ADDR_WIDTH(AW), .ERR_WAIT_CYCLES(W1), .ERR_CNT_WIDTH(CW1)) dut1 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready1), .hreadyout(rdy1), .hresp(resp1),
        .err_clr(err_clr), .err_count(cnt1), .err_addr(addr1), .err_write(wr1), .err_irq(irq1)
    );

    typedef struct {
        logic          rdy;
        logic          err;
        int            cnt;
        logic [AW-1:0] addr;
        logic          wr;
        logic          irq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model: m_pos = -1 when idle, else cycles since the accepting edge.
    // Positions 1..W are wait states, W+1 is the first ERROR, W+2 the second.
    int            m_pos [2];
    int            m_cnt [2];
    logic [AW-1:0] m_addr[2];
    logic          m_wr  [2];
    logic          m_irq [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int wait_of(int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int max_of(int i);
        return (i == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
    endfunction

    function automatic bit m_ready(int i);
        return (m_pos[i] < 0) || (m_pos[i] == wait_of(i) + 2);
    endfunction

    function automatic bit m_err(int i);
        return (m_pos[i] == wait_of(i) + 1) || (m_pos[i] == wait_of(i) + 2);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = -1;
            m_cnt[i]  = 0;
            m_addr[i] = '0;
            m_wr[i]   = 1'b0;
            m_irq[i]  = 1'b0;
        end
    endtask

    // Advance one clock: apply the spec rules to the inputs seen at the edge.
    task automatic step();
        bit   active;
        bit   rd;
        bit   acc;
        exp_t e;
        @(posedge hclk);
        active = hsel && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);
        for (int i = 0; i < 2; i++) begin
            rd = (i == 0) ? hready0 : hready1;
            if (!hreset_n) begin
                model_reset();
            end else begin
                acc = active && rd && m_ready(i);
                if (acc) begin
                    m_pos[i] = 1;
                    $display("txn dut%0d addr=%08h write=%0b clr=%0b t=%0t", i, haddr, hwrite, err_clr, $time);
                    if (LOG_EN) begin
                        if (err_clr) m_cnt[i] = 0;
                        if (m_cnt[i] < max_of(i)) m_cnt[i] = m_cnt[i] + 1;
                        m_addr[i] = haddr;
                        m_wr[i]   = hwrite;
                        m_irq[i]  = 1'b1;
                    end
                end else begin
                    if (m_pos[i] >= 1 && m_pos[i] <= wait_of(i) + 1) m_pos[i] = m_pos[i] + 1;
                    else m_pos[i] = -1;
                    if (LOG_EN && err_clr) begin
                        m_cnt[i] = 0;
                        m_irq[i] = 1'b0;
                    end
                end
            end
            e.rdy  = m_ready(i);
            e.err  = m_err(i);
            e.cnt  = m_cnt[i];
            e.addr = m_addr[i];
            e.wr   = m_wr[i];
            e.irq  = m_irq[i];
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
    endtask

    // hready mimics a bus where this slave is selected; stall models another slave,
    // force_hi drives hready high even while the slave is stalling.
    task automatic cycle(bit sel, htrans_type t, logic [AW-1:0] a, bit w, bit clr, bit stall, bit force_hi);
        hsel    = sel;
        htrans  = t;
        haddr   = a;
        hwrite  = w;
        err_clr = clr;
        hsize   = hsize_type'($urandom_range(0, 7));
        hready0 = (m_ready(0) && !stall) || force_hi;
        hready1 = (m_ready(1) && !stall) || force_hi;
        step();
    endtask

    // Monitor: one expected entry per DUT per clock, compared mid-cycle.
    initial begin
        exp_t e0;
        exp_t e1;
        forever begin
            @(negedge hclk);
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                check("hreadyout0", 64'(rdy0), 64'(e0.rdy));
                check("hresp0",     64'(resp0), 64'(e0.err ? ERROR : OKAY));
                check("err_count0", 64'(cnt0), 64'(e0.cnt));
                check("err_addr0",  64'(addr0), 64'(e0.addr));
                check("err_write0", 64'(wr0), 64'(e0.wr));
                check("err_irq0",   64'(irq0), 64'(e0.irq));
                check("hreadyout1", 64'(rdy1), 64'(e1.rdy));
                check("hresp1",     64'(resp1), 64'(e1.err ? ERROR : OKAY));
                check("err_count1", 64'(cnt1), 64'(e1.cnt));
                check("err_addr1",  64'(addr1), 64'(e1.addr));
                check("err_write1", 64'(wr1), 64'(e1.wr));
                check("err_irq1",   64'(irq1), 64'(e1.irq));
            end
        end
    end

    initial begin
        model_reset();

        // Reset held over two edges with an active transfer presented.
        hreset_n = 1'b0;
        cycle(1, TRANS_NONSEQ, 32'h0000_1234, 1, 0, 0, 0);
        cycle(1, TRANS_NONSEQ, 32'h0000_1238, 1, 0, 0, 0);
        hreset_n = 1'b1;

        repeat (5) cycle(1, TRANS_IDLE, 32'h0000_0100, 0, 0, 0, 0);

        cycle(1, TRANS_NONSEQ, 32'h0000_5000, 1, 0, 0, 0);
        repeat (6) cycle(1, TRANS_IDLE, 32'h0, 0, 0, 0, 0);

        cycle(1, TRANS_NONSEQ, 32'h0000_6004, 0, 0, 0, 0);
        repeat (6) cycle(1, TRANS_IDLE, 32'h0, 0, 0, 0, 0);

        // Continuous NONSEQ: back-to-back errors, saturation, clear racing an accept.
        for (int k = 0; k < 24; k++)
            cycle(1, TRANS_NONSEQ, 32'h0000_7000 + 32'(k * 4), k[0], (k == 14 || k == 15), 0, 0);
        repeat (6) cycle(1, TRANS_IDLE, 32'h0, 0, 0, 0, 0);

        // Clear alone, then BUSY and deselected traffic that must stay OKAY.
        cycle(1, TRANS_IDLE, 32'h0, 0, 1, 0, 0);
        repeat (4) cycle(1, TRANS_BUSY, 32'h0000_8000, 1, 0, 0, 0);
        repeat (4) cycle(0, TRANS_NONSEQ, 32'h0000_9000, 1, 0, 0, 0);
        cycle(1, TRANS_SEQ, 32'h0000_A000, 1, 0, 0, 1);
        repeat (6) cycle(1, TRANS_NONSEQ, 32'h0000_B000, 0, 0, 0, 1);
        repeat (6) cycle(1, TRANS_IDLE, 32'h0, 0, 0, 0, 0);

        // Asynchronous reset while the three-wait instance sits in its wait states.
        cycle(1, TRANS_NONSEQ, 32'h0000_C000, 1, 0, 0, 0);
        cycle(1, TRANS_IDLE, 32'h0, 0, 0, 0, 0);
        @(negedge hclk);
        #1;
        hreset_n = 1'b0;
        #1;
        check("async_rst_hreadyout0", 64'(rdy0), 64'(1));
        check("async_rst_hresp0", 64'(resp0), 64'(OKAY));
        check("async_rst_hreadyout1", 64'(rdy1), 64'(1));
        check("async_rst_hresp1", 64'(resp1), 64'(OKAY));
        check("async_rst_log", 64'({cnt0, cnt1, irq0, irq1, wr0, wr1}), 64'(0));
        check("async_rst_addr", 64'({addr0, addr1}), 64'(0));
        cycle(1, TRANS_NONSEQ, 32'h0000_D000, 1, 0, 0, 0);
        hreset_n = 1'b1;

        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom_range(0, 3) != 0),
                  htrans_type'($urandom_range(0, 3)),
                  AW'($urandom),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        @(negedge hclk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
